// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore-style multicycle control FSM for the 16-bit accumulator processor.
// Walks each instruction through FETCH / DECODE / execute states and issues
// the datapath's source selects, ALU operation, PC source, branch strobe and
// write enables cycle by cycle.
//
// Optional feature macro: CTRL_MEMWAIT_EN
//   Defined   : FETCH, MREAD and MWRITE hold until MemReady=1 is sampled on a
//               rising clock edge. In FETCH, PCWrite/IRWrite are asserted only
//               in the cycle MemReady=1, so PC advances exactly once.
//   Undefined : MemReady is ignored; every memory state lasts one cycle.
//
// Memory handshake: the FSM holds its memory request (MemRead or MemWrite)
// steady in a memory state; MemReady is a single-cycle "done" strobe from the
// memory, and the transfer completes on the rising edge where it is seen high.
//
// Ports:
//   CLK         in   system clock, rising edge
//   Reset       in   asynchronous, active-high reset (FSM -> INIT)
//   Opcode      in   IR[15:12], sampled only in DECODE
//   BrField     in   IR[11:10], branch condition selector
//   MemReady    in   memory done strobe (only with CTRL_MEMWAIT_EN)
//   ALUSrcA     out  0=PC, 1=SP, 2=ACC, 3=unused (datapath forces 0)
//   ALUSrcB     out  0=IR immediate, 1=Memout, 2=constant 2
//   ALUOp       out  000 add, 001 sub, 010 and, 011 or, 100 sll, 101 srl
//   SIGNExt     out  1 = sign-extend the immediate
//   PCSrc       out  0=ALUOut, 1=ALUDirectOut, 2=jump target
//   PCWrite     out  unconditional PC load
//   BranchCycle out  datapath evaluates DOBRANCH and loads PC if true
//   BranchCond  out  BrField during BRANCH, else 0
//   IRWrite     out  IR load
//   IorD        out  0 = address from PC, 1 = from ALUOut
//   MemRead     out  memory read request
//   MemWrite    out  memory write request
//   ACCWrite    out  ACC load
//   SPWrite     out  SP load
//   Illegal     out  one-cycle pulse in DECODE on an undefined opcode
//   Halted      out  high while in HALT
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int               OPW     = 4,
  parameter logic [OPW-1:0]   HALT_OP = OPW'(4'hF)
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] Opcode,
  input  logic [1:0]     BrField,
  input  logic           MemReady,
  output logic [1:0]     ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           SIGNExt,
  output logic [1:0]     PCSrc,
  output logic           PCWrite,
  output logic           BranchCycle,
  output logic [1:0]     BranchCond,
  output logic           IRWrite,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           ACCWrite,
  output logic           SPWrite,
  output logic           Illegal,
  output logic           Halted
);

  localparam logic [OPW-1:0] OP_ADDI  = OPW'(0);
  localparam logic [OPW-1:0] OP_SLL   = OPW'(1);
  localparam logic [OPW-1:0] OP_ADDSP = OPW'(2);
  localparam logic [OPW-1:0] OP_LW    = OPW'(3);
  localparam logic [OPW-1:0] OP_SW    = OPW'(4);
  localparam logic [OPW-1:0] OP_BR    = OPW'(6);
  localparam logic [OPW-1:0] OP_J     = OPW'(7);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_WB     = 4'd4,
    S_ADDR   = 4'd5,
    S_MREAD  = 4'd6,
    S_WB_MEM = 4'd7,
    S_MWRITE = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  // All registered control outputs, grouped so they load in one assignment.
  typedef struct packed {
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       sign_ext;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch_cycle;
    logic [1:0] branch_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       acc_write;
    logic       sp_write;
    logic       halted;
  } ctrl_t;

  state_t         r_state;
  ctrl_t          r_out;
  logic [OPW-1:0] r_op;       // opcode latched at the end of DECODE

  state_t         w_next;
  logic [OPW-1:0] w_op_eff;
  logic           w_illegal;
  logic           w_unused;

  // Output pattern for a given state. Outputs are loaded one edge early from
  // the next state, so the registered outputs line up with the state itself.
  function automatic ctrl_t outputs_for(input state_t s,
                                        input logic [OPW-1:0] op,
                                        input logic [1:0] br);
    ctrl_t o;
    o = '0;
    case (s)
      S_FETCH: begin
        o.mem_read  = 1'b1;
        o.ir_write  = 1'b1;
        o.alu_src_b = 2'd2;
        o.pc_src    = 2'd1;
        o.pc_write  = 1'b1;
      end
      S_DECODE: begin
        // PC + sign-extended offset lands in ALUOut as the branch target.
        o.sign_ext = 1'b1;
      end
      S_EXEC: begin
        if (op == OP_SLL) begin
          o.alu_src_a = 2'd2;
          o.alu_op    = 3'b100;
        end else if (op == OP_ADDSP) begin
          o.alu_src_a = 2'd1;
          o.sign_ext  = 1'b1;
        end else begin
          o.alu_src_a = 2'd2;
          o.sign_ext  = 1'b1;
        end
      end
      S_WB: begin
        if (op == OP_ADDSP) o.sp_write  = 1'b1;
        else                o.acc_write = 1'b1;
      end
      S_ADDR: begin
        o.alu_src_a = 2'd1;
        o.sign_ext  = 1'b1;
      end
      S_MREAD: begin
        o.mem_read = 1'b1;
        o.iord     = 1'b1;
      end
      S_WB_MEM: begin
        // Source A "unused" reads as zero, so OR passes Memout through.
        o.alu_src_a = 2'd3;
        o.alu_src_b = 2'd1;
        o.alu_op    = 3'b011;
        o.acc_write = 1'b1;
      end
      S_MWRITE: begin
        o.mem_write = 1'b1;
        o.iord      = 1'b1;
      end
      S_BRANCH: begin
        o.branch_cycle = 1'b1;
        o.branch_cond  = br;
      end
      S_JUMP: begin
        o.pc_src   = 2'd2;
        o.pc_write = 1'b1;
      end
      S_HALT: begin
        o.halted = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Opcode is only trusted in DECODE; afterwards the latched copy is used.
  assign w_op_eff = (r_state == S_DECODE) ? Opcode : r_op;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT: w_next = S_FETCH;
      S_FETCH: begin
`ifdef CTRL_MEMWAIT_EN
        w_next = MemReady ? S_DECODE : S_FETCH;
`else
        w_next = S_DECODE;
`endif
      end
      S_DECODE: begin
        if (Opcode == HALT_OP) begin
          w_next = S_HALT;
        end else begin
          case (Opcode)
            OP_ADDI, OP_SLL, OP_ADDSP: w_next = S_EXEC;
            OP_LW, OP_SW:              w_next = S_ADDR;
            OP_BR:                     w_next = S_BRANCH;
            OP_J:                      w_next = S_JUMP;
            default:                   w_next = S_FETCH;
          endcase
        end
      end
      S_EXEC:   w_next = S_WB;
      S_WB:     w_next = S_FETCH;
      S_ADDR:   w_next = (r_op == OP_LW) ? S_MREAD : S_MWRITE;
      S_MREAD: begin
`ifdef CTRL_MEMWAIT_EN
        w_next = MemReady ? S_WB_MEM : S_MREAD;
`else
        w_next = S_WB_MEM;
`endif
      end
      S_WB_MEM: w_next = S_FETCH;
      S_MWRITE: begin
`ifdef CTRL_MEMWAIT_EN
        w_next = MemReady ? S_FETCH : S_MWRITE;
`else
        w_next = S_FETCH;
`endif
      end
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_INIT;
    endcase
  end

  // DECODE only falls straight back to FETCH for an undefined opcode.
  assign w_illegal = (r_state == S_DECODE) && (w_next == S_FETCH);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_INIT;
      r_out   <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      r_out   <= outputs_for(w_next, w_op_eff, BrField);
      if (r_state == S_DECODE) r_op <= Opcode;
    end
  end

  assign ALUSrcA     = r_out.alu_src_a;
  assign ALUSrcB     = r_out.alu_src_b;
  assign ALUOp       = r_out.alu_op;
  assign SIGNExt     = r_out.sign_ext;
  assign PCSrc       = r_out.pc_src;
  assign BranchCycle = r_out.branch_cycle;
  assign BranchCond  = r_out.branch_cond;
  assign IorD        = r_out.iord;
  assign MemRead     = r_out.mem_read;
  assign MemWrite    = r_out.mem_write;
  assign ACCWrite    = r_out.acc_write;
  assign SPWrite     = r_out.sp_write;
  assign Halted      = r_out.halted;
  assign Illegal     = w_illegal;

`ifdef CTRL_MEMWAIT_EN
  // While FETCH waits on memory, keep the read request up but hold off the
  // PC/IR loads until the cycle the data is actually there.
  logic w_fetch_stall;
  assign w_fetch_stall = (r_state == S_FETCH) && !MemReady;
  assign PCWrite       = r_out.pc_write && !w_fetch_stall;
  assign IRWrite       = r_out.ir_write && !w_fetch_stall;
  assign w_unused      = 1'b0;
`else
  assign PCWrite  = r_out.pc_write;
  assign IRWrite  = r_out.ir_write;
  assign w_unused = MemReady;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [3:0] Opcode;
  logic [1:0] BrField;
  logic       MemReady;
  logic [1:0] ALUSrcA, ALUSrcB, PCSrc, BranchCond;
  logic [2:0] ALUOp;
  logic       SIGNExt, PCWrite, BranchCycle, IRWrite, IorD, MemRead, MemWrite;
  logic       ACCWrite, SPWrite, Illegal, Halted;

  multicycle_control_unit dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .BrField(BrField),
    .MemReady(MemReady),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .SIGNExt(SIGNExt),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .BranchCycle(BranchCycle),
    .BranchCond(BranchCond), .IRWrite(IRWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .ACCWrite(ACCWrite),
    .SPWrite(SPWrite), .Illegal(Illegal), .Halted(Halted)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] aluop;
    logic       sext;
    logic [1:0] pcsrc;
    logic       pcw;
    logic       bc;
    logic [1:0] bcond;
    logic       irw;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       accw;
    logic       spw;
    logic       ill;
    logic       halted;
  } outs_t;

  logic [21:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic bit is_legal(input logic [3:0] op);
    return (op <= 4'd4) || (op == 4'd6) || (op == 4'd7) || (op == 4'hF);
  endfunction

  // Expected outputs of one named phase of an instruction.
  function automatic logic [21:0] phase(input string name, input logic [3:0] op,
                                        input logic [1:0] br);
    outs_t o;
    o = '0;
    if (name == "FETCH" || name == "FETCH_WAIT") begin
      o.mr = 1; o.b = 2; o.pcsrc = 1;
      o.irw = (name == "FETCH"); o.pcw = (name == "FETCH");
    end else if (name == "DECODE") begin
      o.sext = 1; o.ill = !is_legal(op);
    end else if (name == "EXEC") begin
      if (op == 4'd0) begin o.a = 2; o.sext = 1; end
      if (op == 4'd1) begin o.a = 2; o.aluop = 3'b100; end
      if (op == 4'd2) begin o.a = 1; o.sext = 1; end
    end else if (name == "WB") begin
      if (op == 4'd2) o.spw = 1; else o.accw = 1;
    end else if (name == "ADDR") begin
      o.a = 1; o.sext = 1;
    end else if (name == "MREAD") begin
      o.mr = 1; o.iord = 1;
    end else if (name == "WB_MEM") begin
      o.a = 3; o.b = 1; o.aluop = 3'b011; o.accw = 1;
    end else if (name == "MWRITE") begin
      o.mw = 1; o.iord = 1;
    end else if (name == "BRANCH") begin
      o.bc = 1; o.bcond = br;
    end else if (name == "JUMP") begin
      o.pcsrc = 2; o.pcw = 1;
    end else if (name == "HALT") begin
      o.halted = 1;
    end
    return o;
  endfunction

  // Whole instruction, FETCH first, as the list of phases it walks through.
  task automatic build_seq(input logic [3:0] op, input logic [1:0] br);
    exp_q.push_back(phase("FETCH", op, br));
    exp_q.push_back(phase("DECODE", op, br));
    case (op)
      4'd0, 4'd1, 4'd2: begin
        exp_q.push_back(phase("EXEC", op, br));
        exp_q.push_back(phase("WB", op, br));
      end
      4'd3: begin
        exp_q.push_back(phase("ADDR", op, br));
        exp_q.push_back(phase("MREAD", op, br));
        exp_q.push_back(phase("WB_MEM", op, br));
      end
      4'd4: begin
        exp_q.push_back(phase("ADDR", op, br));
        exp_q.push_back(phase("MWRITE", op, br));
      end
      4'd6: exp_q.push_back(phase("BRANCH", op, br));
      4'd7: exp_q.push_back(phase("JUMP", op, br));
      4'hF: for (int k = 0; k < 10; k++) exp_q.push_back(phase("HALT", op, br));
      default: ;
    endcase
  endtask

  function automatic logic [21:0] observed();
    outs_t o;
    o = '{a: ALUSrcA, b: ALUSrcB, aluop: ALUOp, sext: SIGNExt, pcsrc: PCSrc,
          pcw: PCWrite, bc: BranchCycle, bcond: BranchCond, irw: IRWrite,
          iord: IorD, mr: MemRead, mw: MemWrite, accw: ACCWrite,
          spw: SPWrite, ill: Illegal, halted: Halted};
    return o;
  endfunction

  // ---------------- checking ----------------
  task automatic check_vec(input string tag, input logic [21:0] exp);
    logic [21:0] obs;
    obs = observed();
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    n_checks++;
    assert (!(MemRead && MemWrite)) n_pass++;
    else $error("FAIL %s_rw_excl observed=%b%b expected=not both", tag, MemRead, MemWrite);
    n_checks++;
    assert (!(PCWrite && BranchCycle)) n_pass++;
    else $error("FAIL %s_pc_excl observed=%b%b expected=not both", tag, PCWrite, BranchCycle);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_noise(input bit junk_op);
    if (junk_op) Opcode = 4'($urandom_range(0, 15));
`ifndef CTRL_MEMWAIT_EN
    MemReady = 1'($urandom_range(0, 1));
`endif
  endtask

  // Called at the negedge of a FETCH cycle; returns at the next FETCH negedge.
  task automatic run_instr(input logic [3:0] op, input logic [1:0] br);
    int n;
    logic [21:0] e;
    exp_q.delete();
    build_seq(op, br);
    n = exp_q.size();
    for (int j = 0; j < n; j++) begin
      e = exp_q.pop_front();
      check_vec($sformatf("op%0h_c%0d", op, j), e);
      if (j == 0) begin
        Opcode  = op;
        BrField = br;
        drive_noise(1'b0);
      end else begin
        drive_noise(j >= 2);
      end
      @(negedge CLK);
    end
  endtask

  function automatic logic [3:0] pick_op();
    logic [3:0] legal [7];
    legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
    if ($urandom_range(0, 9) < 8) return legal[$urandom_range(0, 6)];
    if ($urandom_range(0, 1) == 0) return 4'd5;
    return 4'($urandom_range(8, 14));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1; Opcode = 4'd0; BrField = 2'd0; MemReady = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_vec("in_reset", '0);
    @(posedge CLK); #1 Reset = 1'b0;
    @(negedge CLK);
    check_vec("init", '0);
    @(negedge CLK);

    // directed pass over every instruction class
    run_instr(4'd0, 2'd0);
    run_instr(4'd1, 2'd1);
    run_instr(4'd2, 2'd3);
    run_instr(4'd3, 2'd0);
    run_instr(4'd4, 2'd2);
    run_instr(4'd6, 2'b10);
    run_instr(4'd5, 2'd1);
    run_instr(4'd7, 2'd0);
    run_instr(4'd12, 2'd0);

    // randomized instruction stream
    for (int i = 0; i < 40; i++) run_instr(pick_op(), 2'($urandom_range(0, 3)));

    // async reset in the middle of an LW, during MREAD
    check_vec("lw_fetch", phase("FETCH", 4'd3, 2'd0));
    Opcode = 4'd3;
    @(negedge CLK);
    check_vec("lw_decode", phase("DECODE", 4'd3, 2'd0));
    @(negedge CLK);
    check_vec("lw_addr", phase("ADDR", 4'd3, 2'd0));
    @(negedge CLK);
    check_vec("lw_mread", phase("MREAD", 4'd3, 2'd0));
    #1 Reset = 1'b1;
    #1 check_vec("async_reset", '0);
    @(posedge CLK); #1 Reset = 1'b0;
`ifdef CTRL_MEMWAIT_EN
    MemReady = 1'b0;
`endif
    @(negedge CLK);
    check_vec("init2", '0);
`ifdef CTRL_MEMWAIT_EN
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_vec($sformatf("fetch_wait%0d", k), phase("FETCH_WAIT", 4'd0, 2'd0));
    end
    @(posedge CLK); #1 MemReady = 1'b1;
`endif
    @(negedge CLK);
    run_instr(4'd0, 2'd1);

    // HALT parks the FSM; checked for 10 cycles with a wandering opcode
    run_instr(4'hF, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
